// File: rtl/table_port_arbiter.sv
// Two-requester arbiter for a single-port table RAM with a registered command stage and read-data steering.
// Define TABLE_ARB_RR_EN for round-robin arbitration; when it is undefined requester 0 always wins a conflict.
module table_port_arbiter #(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DATA_W     = 63,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_wr,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_wr,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_enable,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [15:0]       conflict_cnt
);

  if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
    $error("table_port_arbiter: RD_LATENCY must be 1 or 2");
  end

  logic              accept;
  logic              sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              mem_enable_q, mem_enable_d;
  logic              mem_wr_en_q, mem_wr_en_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [15:0]       cnt_q, cnt_d;

  // Tag stage 0 lines up with the command cycle; stage RD_LATENCY lines up with returned data.
  logic [RD_LATENCY:0] tag_v_q, tag_v_d;
  logic [RD_LATENCY:0] tag_own_q, tag_own_d;

`ifdef TABLE_ARB_RR_EN
  logic prio_q, prio_d;
`endif

  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (rst_n) begin
`ifdef TABLE_ARB_RR_EN
      r0_gnt = r0_req & (~r1_req | ~prio_q);
      r1_gnt = r1_req & (~r0_req |  prio_q);
`else
      r0_gnt = r0_req;
      r1_gnt = r1_req & ~r0_req;
`endif
    end
  end

  always_comb begin
    accept    = r0_gnt | r1_gnt;
    sel_wr    = r1_gnt ? r1_wr    : r0_wr;
    sel_addr  = r1_gnt ? r1_addr  : r0_addr;
    sel_wdata = r1_gnt ? r1_wdata : r0_wdata;
  end

  always_comb begin
    mem_enable_d = accept;
    mem_wr_en_d  = accept & sel_wr;
    mem_addr_d   = accept ? sel_addr  : mem_addr_q;
    mem_wdata_d  = accept ? sel_wdata : mem_wdata_q;
    tag_v_d      = {tag_v_q[RD_LATENCY-1:0], accept & ~sel_wr};
    tag_own_d    = {tag_own_q[RD_LATENCY-1:0], r1_gnt};
    cnt_d        = cnt_q;
    if (r0_req && r1_req && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

`ifdef TABLE_ARB_RR_EN
  always_comb begin
    prio_d = prio_q;
    if (r0_gnt) begin
      prio_d = 1'b1;
    end else if (r1_gnt) begin
      prio_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_enable_q <= 1'b0;
      mem_wr_en_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      tag_v_q      <= '0;
      tag_own_q    <= '0;
      cnt_q        <= '0;
    end else begin
      mem_enable_q <= mem_enable_d;
      mem_wr_en_q  <= mem_wr_en_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      tag_v_q      <= tag_v_d;
      tag_own_q    <= tag_own_d;
      cnt_q        <= cnt_d;
    end
  end

  assign mem_enable     = mem_enable_q;
  assign mem_wr_en      = mem_wr_en_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;
  assign conflict_cnt   = cnt_q;

  assign r0_rvalid = tag_v_q[RD_LATENCY] & ~tag_own_q[RD_LATENCY];
  assign r1_rvalid = tag_v_q[RD_LATENCY] &  tag_own_q[RD_LATENCY];
  assign r0_rdata  = r0_rvalid ? mem_read_data : '0;
  assign r1_rdata  = r1_rvalid ? mem_read_data : '0;

endmodule

// File: tb/tb_table_port_arbiter.sv
// Directed bench for table_port_arbiter with a one-cycle read-latency RAM model.
module tb_table_port_arbiter;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 63;
  localparam logic [DATA_W-1:0] VAL5  = 63'h1234;
  localparam logic [DATA_W-1:0] VAL1  = 63'h0AAA_5555_0000_1111;
  localparam logic [DATA_W-1:0] VAL2  = 63'h1357_9BDF_2468_ACE0;
  localparam logic [DATA_W-1:0] VALW  = 63'h7FFF_FFFF_FFFF_FFFF;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              r0_req, r0_wr, r1_req, r1_wr;
  logic [ADDR_W-1:0] r0_addr, r1_addr;
  logic [DATA_W-1:0] r0_wdata, r1_wdata;
  logic              r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [DATA_W-1:0] r0_rdata, r1_rdata;
  logic              mem_enable, mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic [15:0]       conflict_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  table_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .mem_enable(mem_enable), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .conflict_cnt(conflict_cnt)
  );

  // RAM model: registered read, one cycle after the command; preload held during reset.
  logic [DATA_W-1:0] ram [32];
  logic [DATA_W-1:0] rd_q;
  always @(posedge clk) begin
    if (!rst_n) begin
      ram[1] <= VAL1;
      ram[2] <= VAL2;
      ram[5] <= VAL5;
    end else if (mem_enable) begin
      if (mem_wr_en) ram[mem_addr] <= mem_write_data;
      else           rd_q <= ram[mem_addr];
    end
  end
  assign mem_read_data = rd_q;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    r0_req = 1'b0; r0_wr = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_wr = 1'b0; r1_addr = '0; r1_wdata = '0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs;
    rst_n = 1'b0;
    r0_req = 1'b1;
    r1_req = 1'b1;
    tick;
    tick;
    tests++;
    if ({r0_gnt, r1_gnt} !== 2'b00) begin
      fails++; $display("FAIL reset_gnt got=%b exp=00", {r0_gnt, r1_gnt});
    end
    tests++;
    if ({mem_enable, mem_wr_en, mem_addr, mem_write_data} !== '0) begin
      fails++; $display("FAIL reset_mem got en=%b we=%b a=%h d=%h exp all 0", mem_enable, mem_wr_en, mem_addr, mem_write_data);
    end
    tests++;
    if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, conflict_cnt} !== '0) begin
      fails++; $display("FAIL reset_ret got rv0=%b rv1=%b rd0=%h rd1=%h cnt=%h exp all 0", r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, conflict_cnt);
    end
    idle_inputs;
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single_read;
    r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 5'd5;
    #1;
    tests++;
    if ({r0_gnt, r1_gnt} !== 2'b01) begin
      fails++; $display("FAIL sr_gnt got=%b exp=01", {r0_gnt, r1_gnt});
    end
    tick;
    r1_req = 1'b0;
    tests++;
    if ({mem_enable, mem_wr_en, mem_addr} !== {1'b1, 1'b0, 5'd5}) begin
      fails++; $display("FAIL sr_cmd got en=%b we=%b a=%0d exp en=1 we=0 a=5", mem_enable, mem_wr_en, mem_addr);
    end
    tick;
    tests++;
    if ({r1_rvalid, r1_rdata} !== {1'b1, VAL5}) begin
      fails++; $display("FAIL sr_ret got rv1=%b rd1=%h exp rv1=1 rd1=%h", r1_rvalid, r1_rdata, VAL5);
    end
    tests++;
    if ({r0_rvalid, r0_rdata} !== '0) begin
      fails++; $display("FAIL sr_r0_quiet got rv0=%b rd0=%h exp 0", r0_rvalid, r0_rdata);
    end
    tick;
    tests++;
    if ({r1_rvalid, mem_enable} !== 2'b00) begin
      fails++; $display("FAIL sr_after got rv1=%b en=%b exp 00", r1_rvalid, mem_enable);
    end
  endtask

  task automatic test_write_read;
    r0_req = 1'b1; r0_wr = 1'b1; r0_addr = 5'd18; r0_wdata = VALW;
    #1;
    tests++;
    if ({r0_gnt, r1_gnt} !== 2'b10) begin
      fails++; $display("FAIL wr_gnt got=%b exp=10", {r0_gnt, r1_gnt});
    end
    tick;
    r0_wr = 1'b0; r0_wdata = '0;
    tests++;
    if ({mem_enable, mem_wr_en, mem_addr, mem_write_data} !== {1'b1, 1'b1, 5'd18, VALW}) begin
      fails++; $display("FAIL wr_cmd got en=%b we=%b a=%0d d=%h exp en=1 we=1 a=18 d=%h", mem_enable, mem_wr_en, mem_addr, mem_write_data, VALW);
    end
    #1;
    tests++;
    if (r0_gnt !== 1'b1) begin
      fails++; $display("FAIL rd_gnt got=%b exp=1", r0_gnt);
    end
    tick;
    r0_req = 1'b0;
    tests++;
    if ({mem_enable, mem_wr_en, mem_addr, r0_rvalid} !== {1'b1, 1'b0, 5'd18, 1'b0}) begin
      fails++; $display("FAIL rd_cmd got en=%b we=%b a=%0d rv0=%b exp en=1 we=0 a=18 rv0=0", mem_enable, mem_wr_en, mem_addr, r0_rvalid);
    end
    tick;
    tests++;
    if ({r0_rvalid, r0_rdata, r1_rvalid} !== {1'b1, VALW, 1'b0}) begin
      fails++; $display("FAIL raw_ret got rv0=%b rd0=%h rv1=%b exp rv0=1 rd0=%h rv1=0", r0_rvalid, r0_rdata, r1_rvalid, VALW);
    end
    tick;
  endtask

  task automatic test_conflict;
    logic [3:0] exp_g;
    logic       exp_c4_r1;
    logic [1:0] exp_g01;
    logic [DATA_W-1:0] e0, e1;
`ifdef TABLE_ARB_RR_EN
    exp_g     = 4'b1010;
    exp_c4_r1 = 1'b0;
`else
    exp_g     = 4'b0000;
    exp_c4_r1 = 1'b1;
`endif
    do_reset;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 5'd1;
        r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 5'd2;
      end else if (k == 4) begin
        r0_req = 1'b0;
        r1_req = exp_c4_r1;
      end else begin
        r1_req = 1'b0;
      end
      #1;
      if (k < 4) begin
        exp_g01 = exp_g[k] ? 2'b01 : 2'b10;
        tests++;
        if ({r0_gnt, r1_gnt} !== exp_g01) begin
          fails++; $display("FAIL cf_gnt[%0d] got=%b exp=%b", k, {r0_gnt, r1_gnt}, exp_g01);
        end
      end else if (k == 4) begin
        tests++;
        if ({r0_gnt, r1_gnt} !== {1'b0, exp_c4_r1}) begin
          fails++; $display("FAIL cf_gnt_tail got=%b exp=%b", {r0_gnt, r1_gnt}, {1'b0, exp_c4_r1});
        end
      end
      if (k >= 2) begin
        e0 = exp_g[k-2] ? '0 : VAL1;
        e1 = exp_g[k-2] ? VAL2 : '0;
        tests++;
        if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !== {~exp_g[k-2], exp_g[k-2], e0, e1}) begin
          fails++; $display("FAIL cf_ret[%0d] got rv0=%b rv1=%b rd0=%h rd1=%h exp rv0=%b rv1=%b rd0=%h rd1=%h",
                            k, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata, ~exp_g[k-2], exp_g[k-2], e0, e1);
        end
      end
      if (k == 5) begin
        tests++;
        if (conflict_cnt !== 16'd4) begin
          fails++; $display("FAIL cf_cnt got=%0d exp=4", conflict_cnt);
        end
      end
      tick;
    end
    tests++;
    if ({r0_rvalid, r1_rvalid, r1_rdata} !== {1'b0, exp_c4_r1, (exp_c4_r1 ? VAL2 : 63'h0)}) begin
      fails++; $display("FAIL cf_tail_ret got rv0=%b rv1=%b rd1=%h exp rv1=%b", r0_rvalid, r1_rvalid, r1_rdata, exp_c4_r1);
    end
    tick;
  endtask

  task automatic test_reset_midflight;
    r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 5'd5;
    #1;
    tests++;
    if (r1_gnt !== 1'b1) begin
      fails++; $display("FAIL rm_gnt got=%b exp=1", r1_gnt);
    end
    tick;
    r1_req = 1'b0;
    rst_n  = 1'b0;
    tests++;
    if (r1_rvalid !== 1'b0) begin
      fails++; $display("FAIL rm_rv_t1 got=%b exp=0", r1_rvalid);
    end
    tick;
    tests++;
    if ({mem_enable, mem_wr_en, mem_addr, mem_write_data, conflict_cnt} !== '0) begin
      fails++; $display("FAIL rm_mem got en=%b we=%b a=%0d d=%h cnt=%0d exp all 0", mem_enable, mem_wr_en, mem_addr, mem_write_data, conflict_cnt);
    end
    tests++;
    if ({r0_rvalid, r1_rvalid, r0_rdata, r1_rdata} !== '0) begin
      fails++; $display("FAIL rm_ret got rv0=%b rv1=%b rd0=%h rd1=%h exp all 0", r0_rvalid, r1_rvalid, r0_rdata, r1_rdata);
    end
    rst_n = 1'b1;
    for (int k = 3; k <= 4; k++) begin
      tick;
      tests++;
      if ({r1_rvalid, r1_rdata} !== '0) begin
        fails++; $display("FAIL rm_rv_t%0d got rv1=%b rd1=%h exp 0", k, r1_rvalid, r1_rdata);
      end
    end
  endtask

  task automatic test_saturation;
    r0_req = 1'b1; r0_wr = 1'b0; r0_addr = 5'd0;
    r1_req = 1'b1; r1_wr = 1'b0; r1_addr = 5'd0;
    for (int unsigned i = 0; i < 65534; i++) tick;
    tests++;
    if (conflict_cnt !== 16'hFFFE) begin
      fails++; $display("FAIL sat_near got=%h exp=fffe", conflict_cnt);
    end
    for (int unsigned i = 65534; i < 70000; i++) tick;
    tests++;
    if (conflict_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL sat_cnt got=%h exp=ffff", conflict_cnt);
    end
    tick;
    tests++;
    if (conflict_cnt !== 16'hFFFF) begin
      fails++; $display("FAIL sat_hold got=%h exp=ffff", conflict_cnt);
    end
    idle_inputs;
    tick;
  endtask

  initial begin
    idle_inputs;
    rst_n = 1'b0;
    test_reset;
    test_single_read;
    test_write_read;
    test_conflict;
    test_reset_midflight;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
